// File: rtl/key_pkg.sv
// Shared definitions for the push-button/switch debouncer: default timing
// constants, the per-channel counter width helper and the channel state type.
package key_pkg;

    // 1 ms sample period at 50 MHz, and 20 ms of agreement before a flip.
    localparam int TICK_DIV_DEF     = 50000;
    localparam int STABLE_TICKS_DEF = 20;

    // Counter must hold values 0..stable_ticks.
    function automatic int cnt_width(input int stable_ticks);
        return $clog2(stable_ticks + 1);
    endfunction

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } deb_state_t;

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: two-flop synchroniser, STABLE/PENDING state machine
// with a small agreement counter, registered level and edge pulses.
module debounce_chan
    import key_pkg::*;
#(
    parameter int   STABLE_TICKS = STABLE_TICKS_DEF,
    parameter logic INIT_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_key,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CNT_W = cnt_width(STABLE_TICKS);

    logic             r_s1;
    logic             r_s2;
    deb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;

    deb_state_t       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_flip;
    logic             w_differs;

    assign w_differs = (r_s2 != r_level);

    // State, counter, synchroniser and output registers; reset wins over all.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= INIT_LEVEL;
            r_s2    <= INIT_LEVEL;
            r_state <= STABLE;
            r_cnt   <= '0;
            r_level <= INIT_LEVEL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_s1    <= i_key;
            r_s2    <= r_s1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= r_level ^ w_flip;
            r_rise  <= w_flip & ~r_level;
            r_fall  <= w_flip & r_level;
        end
    end

    // Next-state logic: only sample-tick cycles can advance the machine.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_flip      = 1'b0;
        if (i_tick) begin
            case (r_state)
                STABLE: begin
                    if (w_differs) begin
                        if (STABLE_TICKS == 1) begin
                            w_flip = 1'b1;
                        end else begin
                            w_cnt_nxt   = CNT_W'(1);
                            w_state_nxt = PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (!w_differs) begin
                        // Bounce: input fell back before the run completed.
                        w_cnt_nxt   = '0;
                        w_state_nxt = STABLE;
                    end else if (r_cnt == CNT_W'(STABLE_TICKS - 1)) begin
                        w_flip      = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = STABLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = STABLE;
                end
            endcase
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/key_debounce.sv
// Input conditioning for the board buttons/switch: one shared sample-tick
// divider feeding N_CH independent debounce channels.
module key_debounce
    import key_pkg::*;
#(
    parameter int   N_CH         = 3,
    parameter int   TICK_DIV     = TICK_DIV_DEF,
    parameter int   STABLE_TICKS = STABLE_TICKS_DEF,
    parameter logic INIT_LEVEL   = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] key_in,
    output logic [N_CH-1:0] key_level,
    output logic [N_CH-1:0] key_rise,
    output logic [N_CH-1:0] key_fall,
    output logic            tick_out
);

    localparam int DIV_W = $clog2(TICK_DIV);

    logic [DIV_W-1:0] r_div;
    logic             w_tick;

    // Tick is a decode of the terminal count, so it is low while in reset.
    assign w_tick   = (r_div == DIV_W'(TICK_DIV - 1));
    assign tick_out = w_tick;

    // Free-running divider 0..TICK_DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        debounce_chan #(
            .STABLE_TICKS (STABLE_TICKS),
            .INIT_LEVEL   (INIT_LEVEL)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .i_tick  (w_tick),
            .i_key   (key_in[g]),
            .o_level (key_level[g]),
            .o_rise  (key_rise[g]),
            .o_fall  (key_fall[g])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios followed by random key activity
// and random resets, checked by a queue-based scoreboard fed from a
// sample-history reference model.
module tb_key_debounce;

    localparam int N  = 3;
    localparam int TD = 4;
    localparam int ST = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] key_in = '0;
    logic [N-1:0] key_level;
    logic [N-1:0] key_rise;
    logic [N-1:0] key_fall;
    logic         tick_out;

    int checks = 0;
    int errors = 0;

    key_debounce #(
        .N_CH         (N),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST),
        .INIT_LEVEL   (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_level (key_level),
        .key_rise  (key_rise),
        .key_fall  (key_fall),
        .tick_out  (tick_out)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int           cyc;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
    } ev_t;

    ev_t          exp_q[$];
    int           cyc_n   = 0;
    int           m_since = 0;   // clean edges since last reset
    logic [N-1:0] hist1   = '0;  // key_in seen one edge ago
    logic [N-1:0] hist2   = '0;  // key_in seen two edges ago (what a tick samples)
    logic [N-1:0] m_level = '0;
    logic         m_tick  = 1'b0;
    int           run[N];

    always @(posedge clk) begin
        logic [N-1:0] flip;
        ev_t          e;
        cyc_n++;
        flip = '0;
        if (rst) begin
            hist1   = '0;
            hist2   = '0;
            m_level = '0;
            m_since = 0;
            for (int c = 0; c < N; c++) run[c] = 0;
        end else begin
            if (m_since % TD == TD - 1) begin
                for (int c = 0; c < N; c++) begin
                    if (hist2[c] != m_level[c]) begin
                        run[c]++;
                        if (run[c] == ST) begin
                            flip[c] = 1'b1;
                            run[c]  = 0;
                        end
                    end else begin
                        run[c] = 0;
                    end
                end
            end
            hist2 = hist1;
            hist1 = key_in;
            m_since++;
            if (flip != '0) begin
                e.cyc  = cyc_n;
                e.rise = flip & ~m_level;
                e.fall = flip & m_level;
                exp_q.push_back(e);
            end
            m_level = m_level ^ flip;
        end
        m_tick = (m_since % TD == TD - 1);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        ev_t e;
        chk("level", key_level, m_level);
        chk("tick", tick_out, m_tick);
        chk("rise_fall_exclusive", key_rise & key_fall, 0);
        if ((key_rise | key_fall) != '0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {key_rise, key_fall}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_cycle", cyc_n, e.cyc);
                chk("pulse_rise", key_rise, e.rise);
                chk("pulse_fall", key_fall, e.fall);
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc_n) begin
            e = exp_q.pop_front();
            chk("missed_pulse", {key_rise, key_fall}, {e.rise, e.fall});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_tick();
        bit seen = 0;
        for (int k = 0; k < 2 * TD && !seen; k++) begin
            @(negedge clk);
            if (tick_out) seen = 1;
        end
        chk("tick_within_bound", seen, 1);
    endtask

    // Waits for a rise (dir=1) or fall (dir=0) pulse on a channel.
    task automatic wait_pulse(input int ch, input bit dir, input string name);
        bit seen = 0;
        for (int k = 0; k < 4 * ST * TD && !seen; k++) begin
            @(negedge clk);
            if (dir ? key_rise[ch] : key_fall[ch]) seen = 1;
        end
        chk(name, seen, 1);
    endtask

    int hold[N];

    initial begin
        // Scenario 1: reset with all keys high.
        rst    = 1'b1;
        key_in = 3'b111;
        repeat (3) @(negedge clk);
        key_in = 3'b000;
        rst    = 1'b0;
        begin
            int first = -1;
            for (int k = 1; k <= 3 * TD && first < 0; k++) begin
                @(negedge clk);
                if (tick_out) first = k;
            end
            // Divider counts 0..TD-1 from the first clean edge.
            chk("first_tick_delay", first, TD - 1);
        end
        repeat (4 * TD) @(negedge clk);

        // Scenario 2: clean press on channel 0.
        key_in[0] = 1'b1;
        wait_pulse(0, 1'b1, "press_rise_seen");
        chk("press_level", key_level, 3'b001);
        @(negedge clk);
        chk("press_rise_one_cycle", key_rise, 3'b000);

        // Scenario 3: channel 1 differs for only two sampled ticks.
        wait_tick();
        key_in[1] = 1'b1;
        repeat (7) @(negedge clk);
        key_in[1] = 1'b0;
        repeat (6 * TD) @(negedge clk);
        chk("bounce_rejected", key_level[1], 1'b0);

        // Scenario 4: release channel 0.
        key_in[0] = 1'b0;
        wait_pulse(0, 1'b0, "release_fall_seen");
        chk("release_level", key_level, 3'b000);
        chk("release_no_rise", key_rise, 3'b000);
        repeat (2 * TD) @(negedge clk);

        // Scenario 5: all channels together.
        key_in = 3'b111;
        wait_pulse(0, 1'b1, "simul_rise_seen");
        chk("simul_rise_all", key_rise, 3'b111);
        chk("simul_level_all", key_level, 3'b111);
        key_in = 3'b000;
        wait_pulse(2, 1'b0, "simul_fall_seen");
        chk("simul_fall_all", key_fall, 3'b111);
        repeat (2 * TD) @(negedge clk);

        // Scenario 6: reset after two differing ticks on channel 2.
        wait_tick();
        key_in[2] = 1'b1;
        wait_tick();
        wait_tick();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * TD) @(negedge clk);
        chk("reset_discards_count", key_level[2], 1'b0);
        wait_pulse(2, 1'b1, "post_reset_rise_seen");
        key_in = 3'b000;
        repeat (5 * TD) @(negedge clk);

        // Random phase: per-channel random hold times, occasional reset.
        for (int c = 0; c < N; c++) hold[c] = 1;
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < N; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    key_in[c] = 1'($urandom_range(0, 1));
                    hold[c]   = $urandom_range(1, 20);
                end
            end
            rst = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        repeat (ST * TD + 10) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
